// File: rtl/kd_cfg_pkg.sv
// kd_cfg_pkg: shared state encoding, default sizes and counter-width helper for the KD-tree config controller
package kd_cfg_pkg;
  typedef enum logic [2:0] {IDLE, DRAIN, LOAD, COMMIT, READY} kd_state_e;
  localparam int KD_STORAGE_WIDTH = 22;
  localparam int KD_NUM_NODES = 31;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/node_wen_decoder.sv
// node_wen_decoder: registered one-hot write strobe for the node selected by cnt
module node_wen_decoder
  import kd_cfg_pkg::*;
#(
  parameter int N  = KD_NUM_NODES,
  parameter int CW = cnt_width(KD_NUM_NODES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] cnt,
  output logic [N-1:0]  node_wen
);
  always_ff @(posedge clk or posedge rst)
    if (rst) node_wen <= '0;
    else node_wen <= en ? N'(1) << cnt : '0;
endmodule

// File: rtl/kd_tree_config_ctrl.sv
// kd_tree_config_ctrl: drains the traversal pipe, loads per-node split words, then reopens queries.
// Define KDCFG_LAST_CHECK_EN to add in_last framing check with sticky cfg_err.
module kd_tree_config_ctrl
  import kd_cfg_pkg::*;
#(
  parameter int STORAGE_WIDTH = KD_STORAGE_WIDTH,
  parameter int NUM_NODES     = KD_NUM_NODES,
  parameter int PIPE_DEPTH    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [STORAGE_WIDTH-1:0] in_wdata,
  output logic [NUM_NODES-1:0]     node_wen,
  output logic [STORAGE_WIDTH-1:0] node_wdata,
  output logic                     query_ready,
  output logic                     busy,
  output logic                     done
`ifdef KDCFG_LAST_CHECK_EN
  ,
  input  logic                     in_last,
  output logic                     cfg_err
`endif
);
  localparam int CW = cnt_width(NUM_NODES);
  localparam int DW = cnt_width(PIPE_DEPTH);
  kd_state_e state, next_state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dcnt;
  logic hs, last, drained;
  logic in_ready_d, busy_d, query_ready_d, done_d;
  assign hs      = in_valid && in_ready;
  assign last    = cnt == CW'(NUM_NODES - 1);
  assign drained = dcnt == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dcnt        <= '0;
      node_wdata  <= '0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      query_ready <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= (state != LOAD) ? '0 : (hs && !last) ? cnt + 1'b1 : cnt;
      dcnt        <= (state != DRAIN) ? DW'(PIPE_DEPTH - 1) : dcnt - 1'b1;
      node_wdata  <= hs ? in_wdata : node_wdata;
      in_ready    <= in_ready_d;
      busy        <= busy_d;
      query_ready <= query_ready_d;
      done        <= done_d;
    end
  always_comb begin
    next_state = (state == IDLE && start)        ? LOAD   :
                 (state == READY && start)       ? DRAIN  :
                 (state == DRAIN && drained)     ? LOAD   :
                 (state == LOAD && hs && last)   ? COMMIT :
                 (state == COMMIT)               ? READY  :
                 (state inside {IDLE, DRAIN, LOAD, READY}) ? state : IDLE;
  end
  // registered outputs are decoded from the upcoming state so they line up with it
  always_comb begin
    in_ready_d    = next_state == LOAD;
    busy_d        = next_state inside {DRAIN, LOAD, COMMIT};
    query_ready_d = next_state == READY;
    done_d        = state == COMMIT;
  end
  node_wen_decoder #(.N(NUM_NODES), .CW(CW)) u_dec (
    .clk      (clk),
    .rst      (rst),
    .en       (hs),
    .cnt      (cnt),
    .node_wen (node_wen)
  );
`ifdef KDCFG_LAST_CHECK_EN
  logic start_ok;
  assign start_ok = start && (state == IDLE || state == READY);
  always_ff @(posedge clk or posedge rst)
    if (rst) cfg_err <= 1'b0;
    else if (start_ok) cfg_err <= 1'b0;
    else if (hs && (in_last != last)) cfg_err <= 1'b1;
`endif
endmodule
